// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
//   fetch_slot_t  : one ring entry {pc, instr, filled, fault}
//   ILEN / PC_W   : instruction and stored-address widths
//   MISALIGN_MASK : address bits that must be zero for a legal fetch
//   ptr_width()   : ring pointer width (index bits plus one wrap bit)
package fetch_pkg;

  localparam int unsigned ILEN = 32;
  localparam int unsigned PC_W = 32;
  localparam logic [1:0] MISALIGN_MASK = 2'b11;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            filled;
    logic            fault;
  } fetch_slot_t;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_slot_ring.sv
// In-order slot ring for the fetch queue.
//   push/push_slot   : reserve the tail slot
//   fill_en/fill_data: complete the oldest unfilled slot with memory data
//   pop              : retire the head slot
//   clear            : drop every slot (pipeline flush)
//   head_slot/head_valid : head entry and whether it is occupied
//   occupancy        : reserved slot count; unfilled: reserved slots awaiting data
module fetch_slot_ring
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              a_reset_n,
  input  logic              clear,
  input  logic              push,
  input  fetch_slot_t       push_slot,
  input  logic              fill_en,
  input  logic [ILEN-1:0]   fill_data,
  input  logic              pop,
  output fetch_slot_t       head_slot,
  output logic              head_valid,
  output logic [PTR_W-1:0]  occupancy,
  output logic [PTR_W-1:0]  unfilled
);

  localparam int unsigned IDX_W = PTR_W - 1;

  fetch_slot_t      slots [DEPTH];
  logic [DEPTH-1:0] slot_valid;
  logic [PTR_W-1:0] head, tail, fill;
  logic [PTR_W-1:0] tail_next, fill_next;
  logic [IDX_W-1:0] head_idx, tail_idx, fill_idx;
  logic             scanning;
  logic             scan_filled;

  assign head_idx   = head[IDX_W-1:0];
  assign tail_idx   = tail[IDX_W-1:0];
  assign fill_idx   = fill[IDX_W-1:0];
  assign occupancy  = tail - head;
  assign head_slot  = slots[head_idx];
  assign head_valid = slot_valid[head_idx];

  always_comb begin
    unfilled = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (slot_valid[IDX_W'(i)] && !slots[IDX_W'(i)].filled)
        unfilled = unfilled + PTR_W'(1);
    end
  end

  // The fill pointer always rests on the oldest unfilled slot, or on tail.
  // After a fill (or a fault push at the resting point) it walks forward over
  // fault slots, which are born filled; a push landing in this same cycle is
  // seen through push_slot since the array is not yet updated.
  always_comb begin
    tail_next   = push ? tail + PTR_W'(1) : tail;
    fill_next   = fill_en ? fill + PTR_W'(1) : fill;
    scanning    = 1'b1;
    scan_filled = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (scanning) begin
        scan_filled = (push && fill_next == tail) ? push_slot.filled
                                                  : slots[fill_next[IDX_W-1:0]].filled;
        if (fill_next == tail_next) scanning = 1'b0;
        else if (scan_filled)       fill_next = fill_next + PTR_W'(1);
        else                        scanning = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!a_reset_n || clear) begin
      head       <= '0;
      tail       <= '0;
      fill       <= '0;
      slot_valid <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) slots[IDX_W'(i)] <= '0;
    end else begin
      if (push) begin
        slots[tail_idx]      <= push_slot;
        slot_valid[tail_idx] <= 1'b1;
        tail                 <= tail_next;
      end
      if (fill_en) begin
        slots[fill_idx].instr  <= fill_data;
        slots[fill_idx].filled <= 1'b1;
      end
      if (pop) begin
        slot_valid[head_idx] <= 1'b0;
        head                 <= head + PTR_W'(1);
      end
      fill <= fill_next;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage between the PC block and decode.
//   cmd_*      : fetch address handshake from the PC
//   imem_req_* : read requests to instruction memory
//   imem_rsp_* : in-order read data, one beat per accepted request
//   flush      : drop all slots; in-flight responses are discarded on arrival
//   dec_*      : head instruction {instr, pc, fault} to decode
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              a_reset_n,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  input  logic              flush,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [DATA_W-1:0] dec_instr,
  output logic [ADDR_W-1:0] dec_pc,
  output logic              dec_fault
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CW    = PTR_W + 1;
  localparam logic [CW-1:0] DEPTH_LIM = CW'(DEPTH);

  logic             misaligned, credit, accept, rsp_fill, pop, head_valid;
  logic [PTR_W-1:0] occupancy, unfilled, drop_cnt;
  logic [CW-1:0]    committed;
  fetch_slot_t      push_slot, head_slot;

  assign misaligned = |(cmd_address[1:0] & MISALIGN_MASK);

  // Slots in use plus responses still owed to flushed slots bound new requests.
  assign committed = {1'b0, occupancy} + {1'b0, drop_cnt};
  assign credit    = committed < DEPTH_LIM;

  assign cmd_ready      = a_reset_n && credit && !flush && (misaligned || imem_req_ready);
  assign imem_req_valid = a_reset_n && cmd_valid && credit && !flush && !misaligned;
  assign imem_req_addr  = a_reset_n ? cmd_address : '0;
  assign accept         = cmd_valid && cmd_ready;

  always_comb begin
    push_slot        = '0;
    push_slot.pc     = PC_W'(cmd_address);
    push_slot.filled = misaligned;
    push_slot.fault  = misaligned;
  end

  assign rsp_fill  = imem_rsp_valid && !flush && drop_cnt == '0 && unfilled != '0;
  assign dec_valid = a_reset_n && head_valid && head_slot.filled && !flush;
  assign pop       = dec_valid && dec_ready;
  assign dec_instr = (a_reset_n && !head_slot.fault) ? DATA_W'(head_slot.instr) : '0;
  assign dec_pc    = a_reset_n ? ADDR_W'(head_slot.pc) : '0;
  assign dec_fault = a_reset_n && head_slot.fault;

  fetch_slot_ring #(.DEPTH(DEPTH)) u_ring (
    .clk        (clk),
    .a_reset_n  (a_reset_n),
    .clear      (flush),
    .push       (accept),
    .push_slot  (push_slot),
    .fill_en    (rsp_fill),
    .fill_data  (ILEN'(imem_rsp_data)),
    .pop        (pop),
    .head_slot  (head_slot),
    .head_valid (head_valid),
    .occupancy  (occupancy),
    .unfilled   (unfilled)
  );

  // On flush every issued-but-unfilled slot becomes a response to discard;
  // a response arriving in the flush cycle itself is one of those.
  always_ff @(posedge clk) begin
    if (!a_reset_n) begin
      drop_cnt <= '0;
    end else if (flush) begin
      if (imem_rsp_valid && (drop_cnt != '0 || unfilled != '0))
        drop_cnt <= drop_cnt + unfilled - PTR_W'(1);
      else
        drop_cnt <= drop_cnt + unfilled;
    end else if (imem_rsp_valid && drop_cnt != '0) begin
      drop_cnt <= drop_cnt - PTR_W'(1);
    end
  end

  a_rsp_expected: assert property (@(posedge clk) disable iff (!a_reset_n)
    !(imem_rsp_valid && drop_cnt == '0 && unfilled == '0));

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int NEVER = 32'h7fff_ffff;

  logic        clk = 1'b0;
  logic        a_reset_n = 1'b0;
  logic [31:0] cmd_address = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        flush = 1'b0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_fault;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .a_reset_n(a_reset_n),
    .cmd_address(cmd_address), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
    .dec_pc(dec_pc), .dec_fault(dec_fault)
  );

  // Expected decode entries, in program order, since the last flush/reset.
  typedef struct { int unsigned id; logic [31:0] pc; logic [31:0] instr; logic fault; int ready_cyc; } exp_t;
  // Memory model: outstanding reads, answered in order.
  typedef struct { int unsigned id; logic [31:0] data; int due; bit stale; } mreq_t;

  exp_t        exp_q[$];
  mreq_t       mem_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int unsigned next_id = 0;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;
  bit          done = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0013;
      32'h4:   return 32'h0010_0093;
      32'h8:   return 32'h0020_0113;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  function automatic int stale_count();
    int n = 0;
    foreach (mem_q[i]) if (mem_q[i].stale) n++;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // One clock cycle: drive at posedge+1, check/advance the model at posedge+4.
  task automatic step(input bit rst_n, input bit cv, input logic [31:0] addr,
                      input bit mr, input bit dr, input bit fl, output bit acc);
    bit    rsp_now, credit, mis, e_ready, e_rv;
    mreq_t m;
    exp_t  e;
    @(posedge clk);
    cyc++;
    #1;
    rsp_now        = rst_n && mem_q.size() > 0 && mem_q[0].due <= cyc;
    a_reset_n      = rst_n;
    cmd_valid      = cv;
    cmd_address    = addr;
    imem_req_ready = mr;
    dec_ready      = dr;
    flush          = fl;
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? mem_q[0].data : $urandom();
    #3;
    acc = cmd_valid && cmd_ready;
    if (!rst_n) begin
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_req_addr", imem_req_addr, 32'd0);
      exp_q.delete();
      mem_q.delete();
    end else begin
      credit  = (exp_q.size() + stale_count()) < DEPTH;
      mis     = (addr & 32'h3) != 0;
      e_ready = credit && !fl && (mis || mr);
      e_rv    = cv && !mis && credit && !fl;
      chk("cmd_ready", 32'(cmd_ready), 32'(e_ready));
      chk("imem_req_valid", 32'(imem_req_valid), 32'(e_rv));
      if (e_rv) chk("imem_req_addr", imem_req_addr, addr);
      if (rsp_now) begin
        m = mem_q.pop_front();
        if (!fl && !m.stale)
          foreach (exp_q[i]) if (exp_q[i].id == m.id) exp_q[i].ready_cyc = cyc + 1;
      end
      if (fl) begin
        exp_q.delete();
        foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      end else if (cv && e_ready) begin
        e.id        = next_id++;
        e.pc        = addr;
        e.fault     = mis;
        e.instr     = mis ? 32'd0 : mem_word(addr);
        e.ready_cyc = mis ? cyc + 1 : NEVER;
        exp_q.push_back(e);
        if (!mis)
          mem_q.push_back('{id: e.id, data: mem_word(addr),
                            due: cyc + int'($urandom_range(lat_max, lat_min)), stale: 1'b0});
      end
    end
  endtask

  task automatic idle(input int n, input bit dr);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'd0, 1'b0, dr, 1'b0, acc);
  endtask

  task automatic send(input logic [31:0] addr, input bit dr);
    bit acc;
    int n = 0;
    do begin
      step(1'b1, 1'b1, addr, 1'b1, dr, 1'b0, acc);
      n++;
    end while (!acc && n < 20);
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout addr=%h actual=not_accepted required=accepted", addr);
    end
  endtask

  // Monitor: every cycle compare decode outputs with the head of the model.
  initial begin
    exp_t h;
    bit   e_valid;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (done) break;
      if (!a_reset_n) begin
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_dec_pc", dec_pc, 32'd0);
        chk("rst_dec_instr", dec_instr, 32'd0);
        chk("rst_dec_fault", 32'(dec_fault), 32'd0);
      end else begin
        e_valid = !flush && exp_q.size() > 0 && exp_q[0].ready_cyc <= cyc;
        chk("dec_valid", 32'(dec_valid), 32'(e_valid));
        if (dec_valid && dec_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dec_pop cyc=%0d actual=pc_%h required=no_entry", cyc, dec_pc);
          end else begin
            h = exp_q.pop_front();
            chk("dec_pc", dec_pc, h.pc);
            chk("dec_instr", dec_instr, h.instr);
            chk("dec_fault", 32'(dec_fault), 32'(h.fault));
          end
        end
      end
    end
  end

  initial begin
    bit          acc;
    int          n;
    logic [31:0] a;
    bit          rst, cv, mr, dr, fl;

    // Reset held two cycles.
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, acc);
    step(1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0, acc);

    // Streaming 0,4,8 with single-cycle memory.
    lat_min = 1; lat_max = 1;
    send(32'h0, 1'b1); send(32'h4, 1'b1); send(32'h8, 1'b1);
    idle(6, 1'b1);

    // Decode stalled: exactly DEPTH accepts, then one more per pop.
    n = 0; a = 32'h40;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, a, 1'b1, 1'b0, 1'b0, acc);
      if (acc) begin n++; a = a + 4; end
    end
    chk("stall_accepts", 32'(n), 32'd4);
    n = 0;
    step(1'b1, 1'b1, a, 1'b1, 1'b1, 1'b0, acc);
    if (acc) begin n++; a = a + 4; end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, a, 1'b1, 1'b0, 1'b0, acc);
      if (acc) begin n++; a = a + 4; end
    end
    chk("one_pop_accepts", 32'(n), 32'd1);
    idle(8, 1'b1);

    // Misaligned fetch between two aligned ones.
    send(32'h4, 1'b1); send(32'h6, 1'b1); send(32'h8, 1'b1);
    idle(5, 1'b1);

    // Flush with three long-latency reads in flight, then restart at 0x100.
    lat_min = 3; lat_max = 3;
    send(32'h0, 1'b1); send(32'h4, 1'b1); send(32'h8, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, acc);
    send(32'h100, 1'b1);
    idle(8, 1'b1);
    n = 0; a = 32'h200;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1, a, 1'b1, 1'b0, 1'b0, acc);
      if (acc) begin n++; a = a + 4; end
    end
    chk("post_flush_credit", 32'(n), 32'd4);
    idle(10, 1'b1);

    // Flush coinciding with a response and a decode handshake.
    lat_min = 1; lat_max = 1;
    send(32'h10, 1'b1); send(32'h14, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, acc);
    chk("flush_dec_valid", 32'(dec_valid), 32'd0);
    chk("flush_rsp_present", 32'(imem_rsp_valid), 32'd1);
    idle(4, 1'b1);
    send(32'h300, 1'b1);
    idle(4, 1'b1);

    // Reset with two filled slots and one read in flight.
    send(32'h0, 1'b0); send(32'h4, 1'b0);
    lat_min = 5; lat_max = 5;
    send(32'h8, 1'b0);
    idle(1, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, acc);
    idle(1, 1'b0);
    chk("post_rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("post_rst_dec_pc", dec_pc, 32'd0);
    chk("post_rst_dec_instr", dec_instr, 32'd0);
    chk("post_rst_dec_fault", 32'(dec_fault), 32'd0);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("post_rst_req_valid", 32'(imem_req_valid), 32'd0);
    lat_min = 1; lat_max = 1;
    send(32'h0, 1'b1);
    idle(4, 1'b1);

    // Randomized traffic.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      a = $urandom() & 32'h0000_FFFC;
      if ($urandom_range(5, 0) == 0) a = a | 32'($urandom_range(3, 1));
      rst = ($urandom_range(299, 0) != 0);
      cv  = ($urandom_range(3, 0) != 0);
      mr  = ($urandom_range(3, 0) != 0);
      dr  = ($urandom_range(2, 0) != 0);
      fl  = ($urandom_range(39, 0) == 0);
      step(rst, cv, a, mr, dr, fl, acc);
    end
    idle(30, 1'b1);

    done = 1'b1;
    @(posedge clk);
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction-fetch stage between the program counter block and decode. Accepts fetch addresses from the PC via a valid/ready handshake and issues them to instruction memory. Holds them in an in-order slot ring until memory returns the instruction words, then presents {instr, pc, fault} to decode. Supports pipeline flush with discard of in-flight memory responses.

## Interface
- DEPTH, 4: number of slots (power of two, ≥2); bounds outstanding requests plus buffered instructions
- ADDR_W, 32: address width
- DATA_W, 32: instruction width
- clk  in  1  clock, all logic on rising edge
- a_reset_n  in  1  synchronous, active-low reset
- cmd_address  in  ADDR_W  fetch address from PC
- cmd_valid  in  1  cmd_address valid
- cmd_ready  out  1  address accepted this cycle (PC advances on valid&&ready)
- imem_req_valid  out  1  memory read request
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  ADDR_W  request address (= cmd_address)
- imem_rsp_valid  in  1  read data valid (in request order, ≥1 cycle after accept)
- imem_rsp_data  in  DATA_W  read data
- flush  in  1  discard all slots and in-flight responses
- dec_valid  out  1  head slot holds a completed instruction
- dec_ready  in  1  decode consumes head
- dec_instr  out  DATA_W  head instruction (0 when fault)
- dec_pc  out  ADDR_W  head address
- dec_fault  out  1  head address was misaligned (cmd_address[1:0]≠0)

## Operation
- State: slot ring (pc, instr, filled, fault per slot), head/tail/fill pointers (log2 DEPTH+1 bits, wrap bit distinguishes full/empty), drop_cnt (0..DEPTH).
- credit = (occupancy + drop_cnt < DEPTH).
- Aligned address: imem_req_valid = cmd_valid && credit && !flush; cmd_ready = imem_req_ready && credit && !flush. On accept, reserve tail slot {pc, filled=0, fault=0}.
- Misaligned address: no memory request; cmd_ready = credit && !flush. Reserve tail slot {pc, instr=0, filled=1, fault=1}.
- Response: if drop_cnt>0, decrement drop_cnt and ignore data. Otherwise write instr into slot at fill pointer, set filled, and advance fill pointer past any fault slots.
- Decode: dec_valid = head.filled && !flush; pop on dec_valid && dec_ready.
- Flush: head=tail=fill=0, all slots invalid. drop_cnt <= drop_cnt + unfilled_issued − (imem_rsp_valid ? 1 : 0); a response coinciding with flush is always discarded. No cmd accept, no pop in the flush cycle.
- Simultaneous accept, response and pop in one cycle: all three take effect; occupancy is net of reserve and pop.
- Full (occupancy+drop_cnt=DEPTH): cmd_ready=0 and imem_req_valid=0 until a pop or drop.
- imem_rsp_valid with no unfilled issued slot and drop_cnt=0 is a protocol error. Assertion only; state unchanged.

## Timing
- Reset (a_reset_n=0 at edge): pointers=0, drop_cnt=0, all filled=0. Outputs: cmd_ready=0, imem_req_valid=0, dec_valid=0, dec_instr=0, dec_pc=0, dec_fault=0, imem_req_addr=0 while held. Reset mid-operation discards everything, with no drop accounting. Memory must also be reset.
- cmd_ready and imem_req_valid are combinational from cmd_valid, imem_req_ready, flush and registered state.
- Minimum latency: address accepted at cycle N, response at N+1, dec_valid at N+2.
- Misaligned: dec_valid at N+1 if it is at head.
- Throughput: one instruction per cycle when memory streams responses.

## Structure
- fetch_pkg: typedef fetch_slot_t {pc, instr, filled, fault}; localparam for pointer width, ILEN=32, misalign mask 2'b11.
- One sub-module: fetch_slot_ring. It holds slot storage, head/tail/fill pointers and full/empty logic. fetch_queue keeps the handshake, credit and drop logic.

## Test plan
- Reset then cmd_address 0,4,8 streamed; memory latency 1 returning 0x00000013, 0x00100093, 0x00200113 → dec_pc 0,4,8 with matching dec_instr on consecutive cycles from cycle 2.
- dec_ready=0 with DEPTH=4 → exactly 4 addresses accepted, then cmd_ready=0. Raising dec_ready for one cycle → one further accept.
- cmd_address 0x00000006 between 0x4 and 0x8 → no memory request for it. Decode sees pc 4, then 6 with dec_fault=1 and dec_instr=0, then 8, in order.
- Three requests in flight (latency 3), flush pulse, new address 0x100 → three late responses dropped. Decode sees only pc 0x100, and drop_cnt returns to 0.
- Flush coincident with response and with dec_valid&&dec_ready → response dropped, no pop reported, dec_valid=0 in that cycle.
- a_reset_n low for one cycle with 2 slots filled and 1 in flight → all outputs 0 next cycle. With memory also reset, fetch restarts cleanly at cmd_address 0.
